uart_rx_deframer: RTL and testbench

//  Serial-to-byte receive stage that sits directly upstream of the game-of-life board controller.
//  It synchronises the raw UART rx pin and majority-samples each bit at mid-period.
//  It checks start and stop bits, then presents the byte on a valid/ready handshake.

---
 rtl/uart_rx_deframer_if.sv | 12 +
 rtl/uart_rx_deframer.sv | 102 ++++++++++
 tb/tb_uart_rx_deframer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deframer_if.sv
// uart_rx_deframer_if: serial pin, enable and byte valid/ready signals of the UART receive stage
interface uart_rx_deframer_if;
  logic       enable;
  logic       rx;
  logic       ready;
  logic [7:0] data;
  logic       valid;
  logic       error;
  logic       overrun;
  modport master (input enable, rx, ready, output data, valid, error, overrun);
  modport slave (output enable, rx, ready, input data, valid, error, overrun);
endinterface

// File: rtl/uart_rx_deframer.sv
// uart_rx_deframer: 8N1 UART receiver with 2-of-3 mid-bit sampling, framing/overrun pulses and valid/ready output
module uart_rx_deframer #(
  parameter int CLOCK_RATE = 24000000,
  parameter int BAUD_RATE  = 115200
) (
  input logic              clk,
  input logic              rst_n,
  uart_rx_deframer_if.master bus
);
  localparam int DIV  = CLOCK_RATE / BAUD_RATE;
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
  localparam logic [CW-1:0] C_LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] C_S0   = CW'(HALF - 1);
  localparam logic [CW-1:0] C_S1   = CW'(HALF);
  localparam logic [CW-1:0] C_DEC  = CW'(HALF + 1);
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
  state_t        state_q, state_d;
  logic          s1_q, s2_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    smp_q, smp_d;
  logic [7:0]    sr_q, sr_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic          overrun_q, overrun_d;
  logic          dec, maj, xfer;
  // next state: bit timing, majority vote, deframing and output handshake
  always_comb begin
    dec       = cnt_q == C_DEC;
    maj       = (smp_q[0] & smp_q[1]) | (s2_q & (smp_q[0] | smp_q[1]));
    xfer      = valid_q & bus.ready;
    state_d   = state_q;
    cnt_d     = cnt_q == C_LAST ? '0 : cnt_q + 1'b1;
    bit_d     = bit_q;
    smp_d     = cnt_q == C_S0 ? {smp_q[1], s2_q} : cnt_q == C_S1 ? {s2_q, smp_q[0]} : smp_q;
    sr_d      = sr_q;
    data_d    = data_q;
    valid_d   = valid_q & ~xfer;
    error_d   = 1'b0;
    overrun_d = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        state_d = bus.enable && !s2_q ? START : IDLE;
      end
      START: state_d = dec && maj ? IDLE : cnt_q == C_LAST ? DATA : START;
      DATA: begin
        sr_d = dec ? {maj, sr_q[7:1]} : sr_q;
        bit_d = cnt_q == C_LAST ? bit_q + 1'b1 : bit_q;
        state_d = cnt_q == C_LAST && bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (dec && bus.enable) begin
        state_d = maj ? IDLE : BRK;
        error_d = ~maj;
        overrun_d = maj & valid_q & ~xfer;
        data_d = maj && (!valid_q || xfer) ? sr_q : data_q;
        valid_d = maj | (valid_q & ~xfer);
      end
      BRK: begin
        cnt_d = '0;
        state_d = s2_q ? IDLE : BRK;
      end
      default: state_d = IDLE;
    endcase
    if (!bus.enable) state_d = IDLE;
  end
  // registers: two-flop rx synchroniser, receiver state and output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_q     <= '0;
      smp_q     <= '0;
      sr_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      s1_q      <= bus.rx;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      smp_q     <= smp_d;
      sr_q      <= sr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      error_q   <= error_d;
      overrun_q <= overrun_d;
    end
  end
  assign bus.data    = data_q;
  assign bus.valid   = valid_q;
  assign bus.error   = error_q;
  assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_uart_rx_deframer.sv
// tb_uart_rx_deframer: directed and randomized frames checked cycle by cycle against an event-level receiver model
module tb_uart_rx_deframer;
  localparam int DIV  = 24000000 / 115200;
  localparam int HALF = DIV / 2;
  localparam int LAT  = 9 * DIV + HALF + 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  uart_rx_deframer_if bus ();
  uart_rx_deframer dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  int         cyc = 0;
  int         checks = 0;
  int         fails = 0;
  logic       chk_on = 1'b0;
  logic       ev_pend = 1'b0;
  int         ev_cyc = 0;
  logic [7:0] ev_byte = '0;
  logic       ev_err = 1'b0;
  logic       m_valid = 1'b0;
  logic [7:0] m_data = '0;
  logic       m_err = 1'b0;
  logic       m_ovr = 1'b0;
  logic       rdy_auto = 1'b0;
  int         rdy_pct = 0;
  int         n_err = 0;
  int         n_ovr = 0;
  int         rise_cyc = -1;
  logic       prev_v = 1'b0;
  wire        hit = ev_pend && (cyc + 1 == ev_cyc);
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask
  // Model: a frame started on the line completes exactly LAT edges after its first low sample;
  // the completion either raises error, loads a free output slot, or is an overrun.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_err   <= 1'b0;
      m_ovr   <= 1'b0;
    end else begin
      m_err   <= hit && ev_err;
      m_ovr   <= hit && !ev_err && m_valid && !bus.ready;
      m_valid <= (hit && !ev_err) || (m_valid && !bus.ready);
      m_data  <= hit && !ev_err && !(m_valid && !bus.ready) ? ev_byte : m_data;
    end
  end
  always @(negedge clk) if (chk_on) begin
    check("valid", bus.valid, m_valid);
    check("data", bus.data, m_data);
    check("error", bus.error, m_err);
    check("overrun", bus.overrun, m_ovr);
    n_err <= n_err + int'(bus.error);
    n_ovr <= n_ovr + int'(bus.overrun);
    prev_v <= bus.valid;
    if (bus.valid && !prev_v) rise_cyc <= cyc;
  end
  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_auto) bus.ready = $urandom_range(0, 999) < rdy_pct;
  endtask
  // gk: frame cycle inverted by a one-cycle glitch; kk: frame cycle where enable (kind 0) or reset (kind 1) drops
  task automatic send_frame(input logic [7:0] b, input logic stop, input int gk, input int kk, input int kind);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    ev_pend = kk < 0;
    ev_cyc = cyc + 1 + LAT;
    ev_byte = b;
    ev_err = !stop;
    for (int k = 0; k < 10 * DIV; k++) begin
      bus.rx = fr[k / DIV] ^ (k == gk);
      if (k == kk) begin
        if (kind == 0) bus.enable = 1'b0;
        else rst_n = 1'b0;
      end
      tick();
    end
  endtask
  task automatic consume();
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
  endtask
  initial begin
    int t0, e0, o0, gk, sb;
    logic [7:0] rb;
    bus.enable = 1'b1;
    bus.rx = 1'b0;
    bus.ready = 1'b0;
    tick();
    chk_on = 1'b1;
    repeat (2) tick();
    check("t1_data", bus.data, 8'h00);
    check("t1_valid", bus.valid, 1'b0);
    check("t1_error", bus.error, 1'b0);
    check("t1_overrun", bus.overrun, 1'b0);
    bus.rx = 1'b1;
    rst_n = 1'b1;
    repeat (20) tick();
    check("t1_idle_valid", bus.valid, 1'b0);
    check("t1_idle_pulses", n_err + n_ovr, 0);
    t0 = cyc;
    send_frame(8'h55, 1'b1, -1, -1, 0);
    check("t2_latency", rise_cyc - (t0 + 1), 1980);
    repeat (500) tick();
    check("t2_valid_held", bus.valid, 1'b1);
    check("t2_data", bus.data, 8'h55);
    consume();
    check("t2_valid_drop", bus.valid, 1'b0);
    o0 = n_ovr;
    send_frame(8'hA3, 1'b1, -1, -1, 0);
    send_frame(8'h0F, 1'b1, -1, -1, 0);
    repeat (5) tick();
    check("t3_overruns", n_ovr - o0, 1);
    check("t3_data", bus.data, 8'hA3);
    check("t3_valid", bus.valid, 1'b1);
    consume();
    check("t3_consumed", bus.valid, 1'b0);
    e0 = n_err;
    send_frame(8'h3C, 1'b0, -1, -1, 0);
    repeat (3000) tick();
    check("t4_errors", n_err - e0, 1);
    check("t4_valid", bus.valid, 1'b0);
    bus.rx = 1'b1;
    repeat (10) tick();
    send_frame(8'h81, 1'b1, -1, -1, 0);
    repeat (5) tick();
    check("t4_data", bus.data, 8'h81);
    check("t4_errors_after", n_err - e0, 1);
    consume();
    e0 = n_err;
    o0 = n_ovr;
    bus.rx = 1'b0;
    repeat (60) tick();
    bus.rx = 1'b1;
    repeat (200) tick();
    check("t5_false_start", {bus.valid, 8'(n_err - e0), 8'(n_ovr - o0)}, 17'h0);
    send_frame(8'hFF, 1'b1, 3 * DIV + HALF, -1, 0);
    repeat (5) tick();
    check("t5_glitch_data", bus.data, 8'hFF);
    check("t5_valid", bus.valid, 1'b1);
    consume();
    send_frame(8'h96, 1'b1, -1, 5 * DIV + 50, 0);
    repeat (20) tick();
    bus.enable = 1'b1;
    repeat (10) tick();
    check("t6_enable_drop", bus.valid, 1'b0);
    send_frame(8'h5A, 1'b1, -1, 3 * DIV + 20, 1);
    check("t6_reset_outputs", {bus.data, bus.valid, bus.error, bus.overrun}, 11'h0);
    rst_n = 1'b1;
    repeat (10) tick();
    send_frame(8'h42, 1'b1, -1, -1, 0);
    repeat (5) tick();
    check("t6_data", bus.data, 8'h42);
    consume();
    rdy_auto = 1'b1;
    for (int f = 0; f < 12; f++) begin
      rb = 8'($urandom);
      sb = $urandom_range(0, 5) != 0;
      rdy_pct = $urandom_range(0, 2) == 0 ? 0 : $urandom_range(0, 1) ? 3 : 400;
      gk = $urandom_range(0, 1) ? int'($urandom_range(0, 8)) * DIV + int'($urandom_range(2, DIV - 1)) : -1;
      send_frame(rb, sb[0], gk, -1, 0);
      bus.rx = 1'b1;
      repeat ($urandom_range(8, 300)) tick();
    end
    rdy_auto = 1'b0;
    consume();
    repeat (3) tick();
    check("end_valid", bus.valid, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
